// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the GF(2^m) arithmetic unit. It owns the 256-bit operand
// register file, drives registered operands and op select, then writes the result back.
module alu_cmd_sequencer #(
    parameter int ALU_LAT = 2,
    parameter int AW      = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [AW-1:0]   cmd_src_a,
    input  logic [AW-1:0]   cmd_src_b,
    input  logic [AW-1:0]   cmd_dst,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [255:0]    load_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [255:0]    rd_data,
    output logic [255:0]    alu_A,
    output logic [255:0]    alu_B,
    output logic [2:0]      alu_sel,
    input  logic [135:0]    alu_C,
    input  logic [127:0]    alu_D,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            ovf
);

    localparam int NREG = 1 << AW;
    localparam int CW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_SQR  = 3'b010;
    localparam logic [2:0] OP_X256 = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b111;

    function automatic logic op_is_valid(input logic [2:0] op);
        case (op)
            OP_MUL, OP_SQR, OP_X256, OP_XOR: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // The 136-bit XOR result lives entirely in C; the other ops split their 256-bit result over C/D.
    function automatic logic [255:0] capture_word(input logic [2:0] sel,
                                                  input logic [135:0] c,
                                                  input logic [127:0] d);
        if (sel == OP_XOR) begin
            return {120'b0, c};
        end else begin
            return {c[127:0], d};
        end
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [255:0]  a_q, a_d, b_q, b_d;
    logic [2:0]    sel_q, sel_d;
    logic          err_q, err_d, ovf_q, ovf_d;
    logic          done_q, done_d, busy_q, busy_d;
    logic [255:0]  rf_q [NREG];
    logic [255:0]  rf_d [NREG];

    // Next-state, register-file update and completion flag computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        rf_d    = rf_q;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                rf_d[load_addr] = load_en ? load_data : rf_q[load_addr];
                sel_d = OP_NONE;
                if (cmd_valid && op_is_valid(cmd_op)) begin
                    a_d     = rf_q[cmd_src_a];
                    b_d     = rf_q[cmd_src_b];
                    sel_d   = cmd_op;
                    dst_d   = cmd_dst;
                    cnt_d   = CNT_INIT;
                    state_d = S_EXEC;
                end else if (cmd_valid) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    rf_d[dst_q] = capture_word(sel_q, alu_C, alu_D);
                    ovf_d   = (sel_q != OP_XOR) ? (|alu_C[135:128]) : 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = S_EXEC;
                end
            end
            S_DONE: begin
                sel_d   = OP_NONE;
                state_d = S_IDLE;
            end
            default: begin
                sel_d   = OP_NONE;
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State, operand and register-file flops; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= OP_NONE;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rf_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rf_q    <= rf_d;
        end
    end

    assign cmd_ready = ~busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ovf       = ovf_q;
    assign alu_A     = a_q;
    assign alu_B     = b_q;
    assign alu_sel   = sel_q;
    assign rd_data   = rf_q[rd_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a behavioural GF(2) arithmetic unit stands in for the
// real one, a register-file model predicts each write-back and a monitor checks every done pulse.
module tb_alu_cmd_sequencer;
    localparam int ALU_LAT = 2;
    localparam int AW = 3;
    localparam logic [2:0] MUL = 3'b001, SQR = 3'b010, X256 = 3'b101, XORS = 3'b111;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_op = 3'b0;
    logic [AW-1:0] cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
    logic load_en = 1'b0;
    logic [AW-1:0] load_addr = '0, rd_addr = '0;
    logic [255:0] load_data = '0, rd_data, alu_A, alu_B;
    logic [2:0] alu_sel;
    logic [135:0] alu_C;
    logic [127:0] alu_D;
    logic busy, done, err, ovf;

    alu_cmd_sequencer #(.ALU_LAT(ALU_LAT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_C(alu_C), .alu_D(alu_D),
        .busy(busy), .done(done), .err(err), .ovf(ovf));

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         err;
        logic         ovf;
        logic [255:0] val;
        int unsigned  due;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    logic [255:0] mrf [8];
    int checks = 0, errors = 0;
    logic inj_ovf = 1'b0;

    function automatic logic [255:0] clmul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] r = '0;
        for (int i = 0; i < 128; i++) if (b[i]) r = r ^ ({128'b0, a} << i);
        return r;
    endfunction

    // Reference: full mathematical result each op is expected to leave in the destination.
    function automatic logic [255:0] op_ref(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b);
        case (op)
            MUL:     return clmul(a[127:0], b[127:0]);
            SQR:     return clmul(a[127:0], a[127:0]);
            X256:    return a ^ b;
            XORS:    return {120'b0, a[135:0] ^ b[135:0]};
            default: return '0;
        endcase
    endfunction

    function automatic logic op_ok(input logic [2:0] op);
        return (op == MUL) || (op == SQR) || (op == X256) || (op == XORS);
    endfunction

    // Behavioural arithmetic unit
    logic [255:0] prod_s, xv_s;
    always_comb begin
        prod_s = clmul(alu_A[127:0], (alu_sel == SQR) ? alu_A[127:0] : alu_B[127:0]);
        xv_s   = alu_A ^ alu_B;
        alu_C  = '0;
        alu_D  = '0;
        case (alu_sel)
            MUL, SQR: begin
                alu_C = {((alu_sel == SQR) && inj_ovf) ? 8'h01 : 8'h00, prod_s[255:128]};
                alu_D = prod_s[127:0];
            end
            X256: begin
                alu_C = {8'h00, xv_s[255:128]};
                alu_D = xv_s[127:0];
            end
            XORS: begin
                alu_C = xv_s[135:0];
                alu_D = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;
            end
            default: begin
                alu_C = '0;
                alu_D = '0;
            end
        endcase
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation; outside done, err/ovf must be 0
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", {255'b0, done}, 256'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("err", {255'b0, err}, {255'b0, mon_e.err});
                    check("ovf", {255'b0, ovf}, {255'b0, mon_e.ovf});
                    check("wb_data", rd_data, mon_e.val);
                    check("done_cycle", 256'(cyc), 256'(mon_e.due));
                end
            end else begin
                check("idle_flags", {254'b0, err, ovf}, 256'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {255'b0, cmd_ready}, 256'd1);
    endtask

    task automatic host_load(input logic [2:0] addr, input logic [255:0] data);
        wait_ready();
        load_en = 1'b1; load_addr = addr; load_data = data;
        @(posedge clk); #1;
        load_en = 1'b0;
        mrf[addr] = data;
    endtask

    // Presents a command (optionally with a same-cycle host load) and records its expected result
    task automatic accept_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] d, input logic ld, input logic [2:0] laddr,
                              input logic [255:0] ldata, output logic [255:0] opa, output logic [255:0] opb);
        exp_t e;
        wait_ready();
        opa = mrf[a];
        opb = mrf[b];
        e.err = !op_ok(op);
        e.ovf = (op == SQR) && inj_ovf;
        e.due = cyc + 1 + (op_ok(op) ? ALU_LAT : 0);
        cmd_valid = 1'b1; cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
        load_en = ld; load_addr = laddr; load_data = ldata;
        if (ld) mrf[laddr] = ldata;
        if (op_ok(op)) mrf[d] = op_ref(op, opa, opb);
        e.val = mrf[d];
        sbq.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0; load_en = 1'b0; rd_addr = d;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                         input logic ld, input logic [2:0] laddr, input logic [255:0] ldata, input logic xload);
        logic [255:0] opa, opb;
        int nwait;
        accept_cmd(op, a, b, d, ld, laddr, ldata, opa, opb);
        nwait = op_ok(op) ? ALU_LAT + 1 : 1;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            check("ready_low", {255'b0, cmd_ready}, 256'd0);
            check("busy_high", {255'b0, busy}, 256'd1);
            if (i == 0) begin
                check("alu_sel", {253'b0, alu_sel}, op_ok(op) ? {253'b0, op} : 256'd0);
                if (op_ok(op)) begin
                    check("alu_A", alu_A, opa);
                    check("alu_B", alu_B, opb);
                end
            end
            if (i == 0 && xload) begin
                load_en = 1'b1; load_addr = 3'($urandom); load_data = {8{$urandom}};
            end else begin
                load_en = 1'b0;
            end
        end
        @(negedge clk);
        load_en = 1'b0;
        check("ready_back", {255'b0, cmd_ready}, 256'd1);
        check("sel_idle", {253'b0, alu_sel}, 256'd0);
    endtask

    initial begin
        logic [255:0] k, pat, opa, opb;
        logic [2:0] ops [8];
        ops = '{MUL, SQR, X256, XORS, MUL, XORS, 3'b000, 3'b100};
        for (int i = 0; i < 8; i++) mrf[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", {255'b0, busy}, 256'd0);
        check("rst_done", {255'b0, done}, 256'd0);
        check("rst_sel", {253'b0, alu_sel}, 256'd0);
        check("rst_A", alu_A, 256'd0);
        check("rst_rd", rd_data, 256'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {255'b0, cmd_ready}, 256'd1);

        k = 256'd1 << 127;
        host_load(3'd1, k);
        host_load(3'd2, k);
        issue(MUL, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, '0, 1'b0);
        k = 256'd1 << 254;
        rd_addr = 3'd3; #1;
        check("mul_corner", rd_data, k);

        pat = {32{8'hF0}};
        host_load(3'd0, pat);
        host_load(3'd4, '1);
        issue(X256, 3'd0, 3'd4, 3'd0, 1'b0, 3'd0, '0, 1'b0);
        rd_addr = 3'd0; #1;
        check("xor256_self", rd_data, ~pat);

        issue(3'b011, 3'd1, 3'd2, 3'd5, 1'b0, 3'd0, '0, 1'b0);

        host_load(3'd6, {8{$urandom}});
        inj_ovf = 1'b1;
        issue(SQR, 3'd6, 3'd1, 3'd7, 1'b0, 3'd0, '0, 1'b0);
        inj_ovf = 1'b0;

        host_load(3'd2, {8{$urandom}});
        issue(MUL, 3'd1, 3'd2, 3'd5, 1'b1, 3'd2, {8{$urandom}}, 1'b0);
        issue(XORS, 3'd3, 3'd4, 3'd6, 1'b0, 3'd0, '0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) host_load(3'($urandom), {8{$urandom}});
            inj_ovf = ($urandom_range(0, 3) == 0);
            issue(ops[$urandom_range(0, 7)], 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 3'($urandom), {8{$urandom}}, 1'($urandom));
        end
        inj_ovf = 1'b0;

        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r); #1;
            check("sweep", rd_data, mrf[r]);
        end

        // Reset during the second EXEC cycle: write dropped, everything back to 0
        accept_cmd(MUL, 3'd1, 3'd2, 3'd6, 1'b0, 3'd0, '0, opa, opb);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sbq.delete();
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        check("mid_rst_outs", {alu_sel, busy, done, err, ovf}, 256'd0);
        check("mid_rst_A", alu_A | alu_B, 256'd0);
        check("mid_rst_dst", rd_data, 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_dst", rd_data, 256'd0);
        check("post_rst_ready", {255'b0, cmd_ready}, 256'd1);

        host_load(3'd1, {8{$urandom}});
        host_load(3'd2, {8{$urandom}});
        issue(MUL, 3'd1, 3'd2, 3'd6, 1'b0, 3'd0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("sb_empty", 256'(sbq.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven sequencer that sits directly upstream of the lower-bit GF(2^m) arithmetic unit (MUL/SQR/XOR/XOR-256). It owns an 8-entry × 256-bit operand register file. It accepts one command at a time over a valid/ready handshake and drives registered operands and the op select into the arithmetic unit. It waits a fixed settle time, then writes the unit's {C_Out, D_Out} result back into the register file and flags completion.

## Interface
Parameters:
- ALU_LAT, 2: cycles the arithmetic unit's outputs are given to settle (≥1).
- AW, 3: register-file address width (2^AW entries).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  op code: 001 MUL, 010 SQR, 101 XOR_256, 111 XOR; others invalid.
- cmd_src_a, cmd_src_b, cmd_dst  in  AW  operand and destination register indices.
- load_en  in  1  host write to register file.
- load_addr  in  AW  host write index.
- load_data  in  256  host write data.
- rd_addr  in  AW  host read index.
- rd_data  out  256  combinational read of regfile[rd_addr].
- alu_A, alu_B  out  256  registered operands to the arithmetic unit.
- alu_sel  out  3  registered op select to the arithmetic unit.
- alu_C  in  136  arithmetic unit C_Out.
- alu_D  in  128  arithmetic unit D_Out.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  invalid op; valid only while done=1, else 0.
- ovf  out  1  result-width violation; valid only while done=1, else 0.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1 and alu_sel=000.
  - On accept (cmd_valid & cmd_ready) with a valid op: latch alu_A=regfile[src_a], alu_B=regfile[src_b], alu_sel=cmd_op and dst; load counter=ALU_LAT-1; go to EXEC.
  - On accept with an invalid op: no operand update, alu_sel stays 000; latch err=1; go to DONE.
- EXEC:
  - Counter decrements each cycle.
  - On the cycle where counter==0: write regfile[dst] per the capture rule, latch ovf, go to DONE.
- DONE: assert done for one cycle; err/ovf driven from latches; return to IDLE with alu_sel=000.
- Capture rule:
  - XOR: regfile[dst]={120'b0, alu_C[135:0]}; ovf=0.
  - MUL, SQR, XOR_256: regfile[dst]={alu_C[127:0], alu_D}; ovf=|alu_C[135:128]. The write still occurs when ovf=1.
- Operands: MUL and SQR use only bits [127:0] of the sources; XOR uses [135:0]. alu_A/alu_B always carry the full 256 bits.
- Host load:
  - Honoured only in IDLE; ignored in EXEC and DONE.
  - Load and accept in the same IDLE cycle: the operand snapshot takes the pre-load value, and the load commits on the same edge.
- src_a==src_b and dst==src are legal. Operands are snapshotted, so overwriting a source has no effect on the command in flight.
- Reset (any time, including mid-EXEC):
  - All regfile entries, alu_A, alu_B, alu_sel, counter, err, ovf, done, busy go to 0; state goes to IDLE; cmd_ready=1 after reset deasserts.
  - An in-flight write is dropped.

## Timing
- Accept at edge T.
  - alu_A/B/sel valid from cycle T+1.
  - EXEC spans cycles T+1..T+ALU_LAT; the write occurs at the edge ending cycle T+ALU_LAT.
  - done=1 in cycle T+ALU_LAT+1, and rd_data already shows the new value in that cycle.
  - cmd_ready=1 again at T+ALU_LAT+2.
- Throughput: one command per ALU_LAT+2 cycles.
- Invalid op: done=1, err=1 in cycle T+1; cmd_ready returns at T+2.
- cmd_ready is low during EXEC and DONE; cmd_valid held in those cycles is not consumed. The source must hold cmd_* stable until accepted.
- alu_C/alu_D are sampled only at the last EXEC cycle; values in other cycles (including Z when alu_sel=000) are ignored.

## Test plan
- Load r1=r2=1<<127, MUL r1,r2→r3 with ALU_LAT=2 and the real unit:
  - done in cycle T+3, err=0, ovf=0.
  - r3 = 1<<254.
  - cmd_ready low for T+1..T+3.
- Load r0=256'h…F0F0 pattern, r4=all-ones, XOR_256 r0,r4→r0: r0 = bitwise NOT of the pattern; the self-overwrite is correct.
- cmd_op=011: done and err in cycle T+1; regfile unchanged; alu_sel stays 000.
- Bench ALU model drives alu_C[135:128]=8'h01 on SQR: ovf=1 with done, and the destination is still written with {alu_C[127:0], alu_D}.
- load_en to r2 with cmd_valid (MUL src r2) in the same IDLE cycle: the product uses the old r2, and r2 holds the new data afterwards. load_en during EXEC is ignored.
- Assert rst in the second EXEC cycle:
  - All outputs read 0 and the destination keeps its pre-command value (0 after reset).
  - done never pulses.
  - A new command accepted after reset completes normally.
